// File: rtl/nway_light_ctrl_pkg.sv
// rtl/nway_light_ctrl_pkg.sv - shared defaults and counter-width helper for the N-way light controller
//  Purpose: default debounce length and auto-off timeout, plus the width function
//           used to size the debounce counters and the auto-off timer.
//  Ports:   none (package).
package nway_light_ctrl_pkg;

  localparam int DEF_DB_CYCLES = 4;
  localparam int DEF_TIMEOUT   = 1000;

  // Bits needed to hold a count from 0 to n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-switch synchroniser and debounce filter
//  Purpose: brings one raw switch level into the clock domain through two flops,
//           then only accepts a new level after DB_CYCLES consecutive cycles of
//           disagreement with the current debounced level.
//  Ports:   clk       in  system clock, rising edge
//           rst       in  asynchronous active-high reset
//           sw        in  raw asynchronous switch level
//           sw_stable out debounced switch level
module sw_debounce
  import nway_light_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_stable
);

  localparam int CW = cnt_width(DB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      sw_stable <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      // Any agreement restarts the run, so only an unbroken run of
      // DB_CYCLES mismatching cycles moves the debounced level.
      if (sync2 == sw_stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        sw_stable <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nway_light_ctrl.sv
// rtl/nway_light_ctrl.sv - N-way light controller top: debounce, parity toggle, optional auto-off
//  Purpose: each debounced switch change toggles the light; simultaneous changes
//           combine by parity. With NWAY_LIGHT_AUTO_OFF_EN defined, a light that
//           was switched on turns itself off after TIMEOUT cycles.
//  Ports:   clk           in  system clock, rising edge
//           rst           in  asynchronous active-high reset
//           sw            in  [N_SW] raw switch levels
//           sw_stable     out [N_SW] debounced switch levels
//           light         out lamp drive, 1 = on
//           toggle_pulse  out one-cycle pulse per switch-caused flip
//           timeout_pulse out one-cycle pulse when auto-off fires (0 without the macro)
//  Config:  NWAY_LIGHT_AUTO_OFF_EN enables the auto-off timer.
module nway_light_ctrl
  import nway_light_ctrl_pkg::*;
#(
  parameter int N_SW      = 3,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_stable,
  output logic            light,
  output logic            toggle_pulse,
  output logic            timeout_pulse
);

  logic [N_SW-1:0] sw_stable_d;
  logic            flip;
  logic            expire;
  logic            light_next;

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw[i]),
      .sw_stable(sw_stable[i])
    );
  end

  // An odd number of debounced bits changing this cycle means a net flip.
  assign flip = ^(sw_stable ^ sw_stable_d);

`ifdef NWAY_LIGHT_AUTO_OFF_EN
  localparam int TW = cnt_width(TIMEOUT);

  logic [TW-1:0] timer;

  // A switch flip in the expiry cycle takes priority over the timer.
  assign expire = light && (timer == '0) && !flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (flip && !light) begin
      timer <= TW'(TIMEOUT - 1);
    end else if (light && (timer != '0)) begin
      timer <= timer - 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    light_next = light;
    if (flip) begin
      light_next = ~light;
    end else if (expire) begin
      light_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_stable_d   <= '0;
      light         <= 1'b0;
      toggle_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      sw_stable_d   <= sw_stable;
      light         <= light_next;
      toggle_pulse  <= flip;
      timeout_pulse <= expire;
    end
  end

endmodule
